ps2_rx_chk: RTL and testbench

//  PS/2 host-side receiver: takes device-to-host frames on ps2c/ps2d and returns
//  the data byte with odd-parity and framing status. Adds an inter-edge watchdog
//  so a stalled device cannot hang the FSM. Sits beside the PS/2 host transmitter

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_clk_filter.sv | 45 ++++
 rtl/ps2_rx_chk.sv | 134 +++++++++++++
 tb/tb_ps2_rx_chk.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: receiver state encoding, frame size and defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

   // Receiver FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DPS  = 2'd1,
      ST_LOAD = 2'd2
   } ps2_rx_state_e;

   localparam int PS2_FRAME_BITS     = 11;
   localparam int PS2_FILTER_LEN_DEF = 8;
   localparam int PS2_TIMEOUT_W_DEF  = 14;

   // Data byte plus parity bit must carry an odd number of ones.
   function automatic logic odd_par_err(input logic [8:0] data_par);
      return ~^data_par;
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock glitch filter: level output only moves after FILTER_LEN equal samples.
// Latency: FILTER_LEN clk cycles from a ps2c transition to fall_edge_o.
// Backpressure: none; free-running on every clock.
module ps2_clk_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic ps2c_i,
   output logic f_ps2c_o,
   output logic fall_edge_o
);

   logic [FILTER_LEN-1:0] filter_q, filter_d;
   logic                  f_ps2c_q, f_ps2c_d;

   // Shift in the raw line; the filtered level flips only on a unanimous window.
   always_comb begin
      filter_d = {ps2c_i, filter_q[FILTER_LEN-1:1]};
      f_ps2c_d = f_ps2c_q;
      if (&filter_d) begin
         f_ps2c_d = 1'b1;
      end else if (~|filter_d) begin
         f_ps2c_d = 1'b0;
      end
   end

   // Filter window and filtered level registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         filter_q <= '0;
         f_ps2c_q <= 1'b0;
      end else begin
         filter_q <= filter_d;
         f_ps2c_q <= f_ps2c_d;
      end
   end

   assign f_ps2c_o    = f_ps2c_q;
   // Edge is flagged in the cycle the filtered level is about to drop.
   assign fall_edge_o = f_ps2c_q & ~f_ps2c_d;

endmodule

// File: rtl/ps2_rx_chk.sv
// PS/2 device-to-host receiver with parity/framing status and an inter-edge watchdog.
// Latency: rx_done_tick_o one cycle after the stop-bit falling edge is detected.
// Backpressure: none; rx_en_i only gates the start of a frame, never an ongoing one.
module ps2_rx_chk
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = PS2_FILTER_LEN_DEF,
   parameter int TIMEOUT_W  = PS2_TIMEOUT_W_DEF
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       rx_en_i,
   input  logic       ps2c_i,
   input  logic       ps2d_i,
   output logic       rx_idle_o,
   output logic       rx_done_tick_o,
   output logic [7:0] dout_o,
   output logic       par_err_o,
   output logic       frm_err_o,
   output logic       to_err_tick_o
);

   ps2_rx_state_e                  state_q, state_d;
   logic [3:0]                     n_q, n_d;
   logic [PS2_FRAME_BITS-1:0]      b_q, b_d;
   logic [TIMEOUT_W-1:0]           wd_q, wd_d;
   logic [7:0]                     dout_q, dout_d;
   logic                           par_err_q, par_err_d;
   logic                           frm_err_q, frm_err_d;
   logic                           d_meta_q, d_sync_q;
   logic                           fall_edge;
   // Filtered level exists for the transmitter; the receiver only needs the edge.
   logic                           f_ps2c_unused;

   ps2_clk_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filter (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .ps2c_i      (ps2c_i),
      .f_ps2c_o    (f_ps2c_unused),
      .fall_edge_o (fall_edge)
   );

   // Two-flop synchronizer for the asynchronous data line.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         d_meta_q <= 1'b0;
         d_sync_q <= 1'b0;
      end else begin
         d_meta_q <= ps2d_i;
         d_sync_q <= d_meta_q;
      end
   end

   // Frame FSM: bit capture, watchdog, and status computed on the stop-bit edge.
   always_comb begin
      state_d        = state_q;
      n_d            = n_q;
      b_d            = b_q;
      wd_d           = wd_q;
      dout_d         = dout_q;
      par_err_d      = par_err_q;
      frm_err_d      = frm_err_q;
      rx_idle_o      = 1'b0;
      rx_done_tick_o = 1'b0;
      to_err_tick_o  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rx_idle_o = 1'b1;
            // A start edge with data high is noise, not a frame.
            if (fall_edge && rx_en_i && !d_sync_q) begin
               b_d     = {d_sync_q, b_q[PS2_FRAME_BITS-1:1]};
               n_d     = 4'd9;
               wd_d    = '0;
               state_d = ST_DPS;
            end
         end
         ST_DPS: begin
            // An edge in the expiry cycle still counts; the watchdog loses.
            if (fall_edge) begin
               b_d  = {d_sync_q, b_q[PS2_FRAME_BITS-1:1]};
               wd_d = '0;
               if (n_q == 4'd0) begin
                  state_d   = ST_LOAD;
                  dout_d    = b_d[8:1];
                  par_err_d = odd_par_err(b_d[9:1]);
                  frm_err_d = b_d[0] | ~b_d[10];
               end else begin
                  n_d = n_q - 4'd1;
               end
            end else if (&wd_q) begin
               to_err_tick_o = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         ST_LOAD: begin
            rx_done_tick_o = 1'b1;
            state_d        = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM, datapath and status registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         n_q       <= '0;
         b_q       <= '0;
         wd_q      <= '0;
         dout_q    <= '0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         b_q       <= b_d;
         wd_q      <= wd_d;
         dout_q    <= dout_d;
         par_err_q <= par_err_d;
         frm_err_q <= frm_err_d;
      end
   end

   assign dout_o    = dout_q;
   assign par_err_o = par_err_q;
   assign frm_err_o = frm_err_q;

endmodule

// File: tb/tb_ps2_rx_chk.sv
// Bench for ps2_rx_chk: directed PS/2 frames plus randomized frames vs a frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_rx_chk;

   localparam int H  = 30;   // ps2c half-period in clk cycles
   localparam int TW = 14;

   logic       clk = 1'b0;
   logic       reset, rx_en, ps2c, ps2d;
   logic       rx_idle, rx_done_tick, par_err, frm_err, to_err_tick;
   logic [7:0] dout;

   int n_chk = 0, n_pass = 0;
   int cyc = 0, done_cnt = 0, to_cnt = 0, busy_cnt = 0, to_cyc = 0, last_fall = 0;
   bit idle_chk = 1'b0;

   // Frame-level model of the registered status outputs
   logic [7:0] m_dout;
   logic       m_par, m_frm;

   ps2_rx_chk #(.FILTER_LEN(8), .TIMEOUT_W(TW)) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .rx_en_i        (rx_en),
      .ps2c_i         (ps2c),
      .ps2d_i         (ps2d),
      .rx_idle_o      (rx_idle),
      .rx_done_tick_o (rx_done_tick),
      .dout_o         (dout),
      .par_err_o      (par_err),
      .frm_err_o      (frm_err),
      .to_err_tick_o  (to_err_tick)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Pulse monitor, sampled on the falling clock edge
   always @(negedge clk) begin
      if (idle_chk) begin
         chk("idle_after_done", {31'd0, rx_idle}, 32'd1);
         idle_chk = 1'b0;
      end
      if (rx_done_tick === 1'b1) begin
         done_cnt++;
         idle_chk = 1'b1;
      end
      if (to_err_tick === 1'b1) begin
         to_cnt++;
         to_cyc = cyc;
      end
      if (rx_idle !== 1'b1) busy_cnt++;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [10:0] mk(input logic [7:0] d, input logic par, input logic stop);
      return {stop, par, d, 1'b0};
   endfunction

   // Drive nbits of a frame LSB first; data changes mid-high, optional 5-cycle low glitch
   task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch,
                            input int en_drop_at);
      for (int i = 0; i < nbits; i++) begin
         if (i == en_drop_at) rx_en = 1'b0;
         for (int c = 0; c < H; c++) begin
            ps2c = (glitch && c >= 18 && c < 23) ? 1'b0 : 1'b1;
            if (c == H / 2) ps2d = bits[i];
            tick();
         end
         ps2c      = 1'b0;
         last_fall = cyc;
         tick(H);
      end
      ps2c = 1'b1;
      tick(H);
      ps2d = 1'b1;
   endtask

   task automatic run_frame(input string tag, input logic [7:0] d, input logic par,
                            input logic stop, input bit glitch, input int en_drop_at,
                            input bit expect_done);
      int d0, t0;
      d0 = done_cnt;
      t0 = to_cnt;
      send_bits(mk(d, par, stop), 11, glitch, en_drop_at);
      if (expect_done) begin
         m_dout = d;
         m_par  = ($countones({d, par}) % 2) == 0;
         m_frm  = (stop != 1'b1);
      end
      chk({tag, "_done"}, done_cnt - d0, expect_done ? 32'd1 : 32'd0);
      chk({tag, "_to"}, to_cnt - t0, 32'd0);
      chk({tag, "_dout"}, {24'd0, dout}, {24'd0, m_dout});
      chk({tag, "_par"}, {31'd0, par_err}, {31'd0, m_par});
      chk({tag, "_frm"}, {31'd0, frm_err}, {31'd0, m_frm});
   endtask

   // Hard stop if the run ever stalls
   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL global_timeout: cycle %0d reached, required finish before it", cyc);
      $fatal(1);
   end

   initial begin
      int d0, t0, b0, lat;
      logic [7:0] rd;
      logic       rpar, rstop;
      reset = 1'b1; rx_en = 1'b1; ps2c = 1'b1; ps2d = 1'b1;
      m_dout = 8'h00; m_par = 1'b0; m_frm = 1'b0;
      tick(5);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_idle", {31'd0, rx_idle}, 32'd1);
      chk("rst_dout", {24'd0, dout}, 32'd0);
      chk("rst_par", {31'd0, par_err}, 32'd0);
      chk("rst_frm", {31'd0, frm_err}, 32'd0);
      chk("rst_done", {31'd0, rx_done_tick}, 32'd0);
      chk("rst_to", {31'd0, to_err_tick}, 32'd0);
      tick(20);

      // Good, parity-error and framing-error frames
      run_frame("t1_5a", 8'h5A, 1'b1, 1'b1, 1'b0, -1, 1'b1);
      run_frame("t2_00", 8'h00, 1'b0, 1'b1, 1'b0, -1, 1'b1);
      run_frame("t3_f0", 8'hF0, 1'b1, 1'b0, 1'b0, -1, 1'b1);

      // Stall after d3: watchdog abort, status untouched
      d0 = done_cnt; t0 = to_cnt;
      send_bits(mk(8'h0F, 1'b1, 1'b1), 5, 1'b0, -1);
      for (int k = 0; k < 17500 && to_cnt == t0; k++) tick();
      lat = to_cyc - last_fall;
      chk("t4_to_cnt", to_cnt - t0, 32'd1);
      chk("t4_to_lat_in_window", {31'd0, (lat >= 2**TW && lat <= 2**TW + 40)}, 32'd1);
      chk("t4_no_done", done_cnt - d0, 32'd0);
      chk("t4_dout_kept", {24'd0, dout}, {24'd0, m_dout});
      chk("t4_frm_kept", {31'd0, frm_err}, {31'd0, m_frm});
      tick(2);
      chk("t4_idle", {31'd0, rx_idle}, 32'd1);
      run_frame("t4_1c", 8'h1C, 1'b0, 1'b1, 1'b0, -1, 1'b1);
      chk("t4_single_to", to_cnt - t0, 32'd1);

      // Glitches and a start edge with data high
      d0 = done_cnt; b0 = busy_cnt;
      send_bits(11'h7FF, 1, 1'b1, -1);
      tick(H);
      chk("t5_start_hi_busy", busy_cnt - b0, 32'd0);
      chk("t5_start_hi_done", done_cnt - d0, 32'd0);
      run_frame("t5_glitch", 8'hA7, 1'b0, 1'b1, 1'b1, -1, 1'b1);

      // rx_en low for a whole frame, then dropped mid-frame
      b0 = busy_cnt;
      rx_en = 1'b0;
      run_frame("t6_en0", 8'h33, 1'b1, 1'b1, 1'b0, -1, 1'b0);
      chk("t6_en0_busy", busy_cnt - b0, 32'd0);
      rx_en = 1'b1;
      run_frame("t6_drop", 8'hC3, 1'b1, 1'b1, 1'b0, 4, 1'b1);
      rx_en = 1'b1;

      // Reset mid-frame after d5
      d0 = done_cnt; t0 = to_cnt;
      send_bits(mk(8'h6B, 1'b0, 1'b1), 7, 1'b0, -1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      m_dout = 8'h00; m_par = 1'b0; m_frm = 1'b0;
      chk("t6_rst_idle", {31'd0, rx_idle}, 32'd1);
      chk("t6_rst_dout", {24'd0, dout}, 32'd0);
      chk("t6_rst_par", {31'd0, par_err}, 32'd0);
      chk("t6_rst_frm", {31'd0, frm_err}, 32'd0);
      reset = 1'b0;
      b0 = busy_cnt;
      tick(100);
      chk("t6_rst_no_done", done_cnt - d0, 32'd0);
      chk("t6_rst_no_to", to_cnt - t0, 32'd0);
      chk("t6_rst_busy", busy_cnt - b0, 32'd0);

      // Randomized frames: good, parity-flipped, or bad stop
      for (int r = 0; r < 12; r++) begin
         int mode;
         rd    = 8'($urandom);
         mode  = int'($urandom_range(0, 3));
         rpar  = ~^rd;
         rstop = 1'b1;
         if (mode == 0) rpar = ~rpar;
         if (mode == 1) rstop = 1'b0;
         run_frame($sformatf("rnd%0d", r), rd, rpar, rstop, 1'b0, -1, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
